// File: rtl/pipeline_pkg.sv
// Shared types for the pipeline hazard/forwarding controller: shadow stage entry,
// forward-select encoding and MEM-wait FSM states.
package pipeline_pkg;

    // Shadow entries carry register addresses at this fixed width; narrower
    // REG_AW values are zero-extended into it.
    localparam int unsigned REG_AW_MAX = 8;

    typedef struct packed {
        logic                  valid;
        logic [REG_AW_MAX-1:0] rs1;
        logic [REG_AW_MAX-1:0] rs2;
        logic                  use1;
        logic                  use2;
        logic [REG_AW_MAX-1:0] rd;
        logic                  wre;
        logic                  is_load;
    } stage_info_t;

    typedef enum logic [1:0] {
        FWD_NONE = 2'd0,
        FWD_WB   = 2'd1,
        FWD_MEM  = 2'd2
    } fwd_sel_t;

    typedef enum logic {
        HZ_RUN      = 1'b0,
        HZ_MEM_WAIT = 1'b1
    } hz_state_t;

endpackage

// File: rtl/hazard_match.sv
// Combinational compare of one shadow entry's destination against a source
// register, with optional hardwired-zero masking of register 0.
module hazard_match
    import pipeline_pkg::*;
#(
    parameter int unsigned ZERO_REG_EN = 0
) (
    input  logic                  valid,
    input  logic                  wre,
    input  logic [REG_AW_MAX-1:0] rd,
    input  logic [REG_AW_MAX-1:0] src,
    input  logic                  use_src,
    output logic                  match
);

    assign match = valid && wre && use_src && (rd == src)
                   && !((ZERO_REG_EN != 0) && (src == '0));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage pipeline: keeps a shadow
// EX/MEM/WB occupancy copy and derives stalls, flushes and forwarding selects.
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int unsigned REG_AW      = 4,
    parameter int unsigned MEM_LATENCY = 1,
    parameter int unsigned ZERO_REG_EN = 0,
    parameter int unsigned CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dec_valid,
    input  logic [REG_AW-1:0] dec_rs1,
    input  logic [REG_AW-1:0] dec_rs2,
    input  logic              dec_use_rs1,
    input  logic              dec_use_rs2,
    input  logic [REG_AW-1:0] dec_rd,
    input  logic              dec_wre,
    input  logic              dec_is_load,
    input  logic              dec_is_branch,
    input  logic              branch_taken,
    input  logic              cnt_clear,
    output logic              stall_front,
    output logic              bubble_ex,
    output logic              stall_back,
    output logic              flush_decode,
    output logic [1:0]        fwd_sel_a,
    output logic [1:0]        fwd_sel_b,
    output logic [CNT_W-1:0]  stall_cycles
);

    localparam int unsigned AW     = REG_AW_MAX;
    localparam int unsigned WAIT_W = $clog2(MEM_LATENCY) + 1;

    stage_info_t       ex_q, mem_q, wb_q;
    stage_info_t       dec_entry;
    hz_state_t         state;
    logic [WAIT_W-1:0] wait_cnt;

    logic [AW-1:0] dec_rs1_x, dec_rs2_x, dec_rd_x;
    assign dec_rs1_x = AW'(dec_rs1);
    assign dec_rs2_x = AW'(dec_rs2);
    assign dec_rd_x  = AW'(dec_rd);

    // Compare slots: 0/1 decode vs ex, 2/3 decode vs mem, 4/5 ex vs mem, 6/7 ex vs wb.
    logic          m_valid [8];
    logic          m_wre   [8];
    logic [AW-1:0] m_rd    [8];
    logic [AW-1:0] m_src   [8];
    logic          m_use   [8];
    logic          hit     [8];

    assign m_valid = '{ex_q.valid, ex_q.valid, mem_q.valid, mem_q.valid,
                       mem_q.valid, mem_q.valid, wb_q.valid, wb_q.valid};
    assign m_wre   = '{ex_q.wre, ex_q.wre, mem_q.wre, mem_q.wre,
                       mem_q.wre, mem_q.wre, wb_q.wre, wb_q.wre};
    assign m_rd    = '{ex_q.rd, ex_q.rd, mem_q.rd, mem_q.rd,
                       mem_q.rd, mem_q.rd, wb_q.rd, wb_q.rd};
    assign m_src   = '{dec_rs1_x, dec_rs2_x, dec_rs1_x, dec_rs2_x,
                       ex_q.rs1, ex_q.rs2, ex_q.rs1, ex_q.rs2};
    assign m_use   = '{dec_use_rs1, dec_use_rs2, dec_use_rs1, dec_use_rs2,
                       ex_q.use1, ex_q.use2, ex_q.use1, ex_q.use2};

    for (genvar i = 0; i < 8; i++) begin : g_match
        hazard_match #(
            .ZERO_REG_EN(ZERO_REG_EN)
        ) u_match (
            .valid  (m_valid[i]),
            .wre    (m_wre[i]),
            .rd     (m_rd[i]),
            .src    (m_src[i]),
            .use_src(m_use[i]),
            .match  (hit[i])
        );
    end

    logic in_wait, load_use, branch_hz, hazard;
    assign in_wait   = (state == HZ_MEM_WAIT);
    assign load_use  = dec_valid && ex_q.is_load && (hit[0] || hit[1]);
    assign branch_hz = dec_valid && dec_is_branch
                       && (hit[0] || hit[1] || (mem_q.is_load && (hit[2] || hit[3])));
    assign hazard    = !in_wait && (load_use || branch_hz);

    assign stall_front  = in_wait || hazard;
    assign bubble_ex    = hazard;
    assign stall_back   = in_wait;
    // Gated by reset so decode inputs cannot raise a flush while held in reset.
    assign flush_decode = reset && !in_wait && !hazard
                          && dec_valid && dec_is_branch && branch_taken;

    fwd_sel_t fwd_a, fwd_b;
    always_comb begin
        fwd_a = FWD_NONE;
        fwd_b = FWD_NONE;
        if (hit[4] && !mem_q.is_load)      fwd_a = FWD_MEM;
        else if (hit[6])                   fwd_a = FWD_WB;
        if (hit[5] && !mem_q.is_load)      fwd_b = FWD_MEM;
        else if (hit[7])                   fwd_b = FWD_WB;
    end
    assign fwd_sel_a = fwd_a;
    assign fwd_sel_b = fwd_b;

    always_comb begin
        dec_entry = '0;
        if (dec_valid && !bubble_ex && !flush_decode) begin
            dec_entry.valid   = 1'b1;
            dec_entry.rs1     = dec_rs1_x;
            dec_entry.rs2     = dec_rs2_x;
            dec_entry.use1    = dec_use_rs1;
            dec_entry.use2    = dec_use_rs2;
            dec_entry.rd      = dec_rd_x;
            dec_entry.wre     = dec_wre;
            dec_entry.is_load = dec_is_load;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else if (!stall_back) begin
            ex_q  <= dec_entry;
            mem_q <= ex_q;
            wb_q  <= mem_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= HZ_RUN;
            wait_cnt <= '0;
        end else begin
            case (state)
                HZ_RUN: begin
                    if ((MEM_LATENCY > 1) && ex_q.valid && ex_q.is_load) begin
                        state    <= HZ_MEM_WAIT;
                        wait_cnt <= WAIT_W'(MEM_LATENCY - 1);
                    end
                end
                HZ_MEM_WAIT: begin
                    wait_cnt <= wait_cnt - WAIT_W'(1);
                    if (wait_cnt == WAIT_W'(1)) state <= HZ_RUN;
                end
                default: state <= HZ_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                 stall_cycles <= '0;
        else if (cnt_clear)                         stall_cycles <= '0;
        else if (stall_front && stall_cycles != '1) stall_cycles <= stall_cycles + CNT_W'(1);
    end

    logic unused_shadow;
    assign unused_shadow = ^{mem_q.rs1, mem_q.rs2, mem_q.use1, mem_q.use2,
                             wb_q.rs1, wb_q.rs2, wb_q.use1, wb_q.use2, wb_q.is_load};

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: two controllers (latency 1 / latency 3 with zero-reg and 4-bit
// counter) driven in lockstep and compared against a behavioural pipeline model.
module tb_pipeline_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b0;
    logic       dec_valid = 1'b0, dec_use_rs1 = 1'b0, dec_use_rs2 = 1'b0;
    logic [3:0] dec_rs1 = '0, dec_rs2 = '0, dec_rd = '0;
    logic       dec_wre = 1'b0, dec_is_load = 1'b0, dec_is_branch = 1'b0;
    logic       branch_taken = 1'b0, cnt_clear = 1'b0;

    logic        sf_a, bx_a, sb_a, fl_a, sf_b, bx_b, sb_b, fl_b;
    logic [1:0]  fa_a, fb_a, fa_b, fb_b;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;

    pipeline_hazard_ctrl #(.REG_AW(4), .MEM_LATENCY(1), .ZERO_REG_EN(0), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2), .dec_rd(dec_rd), .dec_wre(dec_wre),
        .dec_is_load(dec_is_load), .dec_is_branch(dec_is_branch), .branch_taken(branch_taken),
        .cnt_clear(cnt_clear), .stall_front(sf_a), .bubble_ex(bx_a), .stall_back(sb_a),
        .flush_decode(fl_a), .fwd_sel_a(fa_a), .fwd_sel_b(fb_a), .stall_cycles(cnt_a));

    pipeline_hazard_ctrl #(.REG_AW(4), .MEM_LATENCY(3), .ZERO_REG_EN(1), .CNT_W(4)) dut_b (
        .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2), .dec_rd(dec_rd), .dec_wre(dec_wre),
        .dec_is_load(dec_is_load), .dec_is_branch(dec_is_branch), .branch_taken(branch_taken),
        .cnt_clear(cnt_clear), .stall_front(sf_b), .bubble_ex(bx_b), .stall_back(sb_b),
        .flush_decode(fl_b), .fwd_sel_a(fa_b), .fwd_sel_b(fb_b), .stall_cycles(cnt_b));

    typedef struct {
        bit v; int rs1; int rs2; bit u1; bit u2; int rd; bit we; bit ld; bit br; bit tk; bit clr;
    } instr_t;

    typedef struct {
        bit sf; bit bx; bit sb; bit fl; int fa; int fb; int cnt;
    } exp_t;

    int n_checks = 0;
    int n_fail   = 0;
    bit done     = 0;

    exp_t qa[$];
    exp_t qb[$];

    // Reference model: one in-flight instruction record per stage plus a count of
    // remaining RAM wait cycles.
    instr_t pex[2], pmem[2], pwb[2];
    int     wleft[2];
    int     cnt[2];
    int     lat[2]  = '{1, 3};
    bit     zr[2]   = '{1'b0, 1'b1};
    int     cmax[2] = '{65535, 15};

    function automatic instr_t nop();
        instr_t s = '{default: 0};
        return s;
    endfunction

    function automatic instr_t alu(int rd, int rs1, int rs2);
        instr_t s = '{default: 0};
        s.v = 1; s.rd = rd; s.rs1 = rs1; s.rs2 = rs2; s.u1 = 1; s.u2 = 1; s.we = 1;
        return s;
    endfunction

    function automatic instr_t lw(int rd, int rs1);
        instr_t s = alu(rd, rs1, 0);
        s.u2 = 0; s.ld = 1;
        return s;
    endfunction

    function automatic instr_t beq(int rs1, int rs2, bit tk);
        instr_t s = alu(0, rs1, rs2);
        s.we = 0; s.br = 1; s.tk = tk;
        return s;
    endfunction

    function automatic bit hits(instr_t e, int src, bit u, bit z);
        return e.v && e.we && u && (e.rd == src) && !(z && src == 0);
    endfunction

    function automatic int fwd(int k, int src, bit u);
        if (hits(pmem[k], src, u, zr[k]) && !pmem[k].ld) return 2;
        if (hits(pwb[k], src, u, zr[k])) return 1;
        return 0;
    endfunction

    task automatic step(input int k, input instr_t s, input bit rst_n, output exp_t x);
        bit wt, lu, bh, hz;
        x = '{default: 0};
        if (!rst_n) begin
            pex[k] = nop(); pmem[k] = nop(); pwb[k] = nop();
            wleft[k] = 0; cnt[k] = 0;
            return;
        end
        wt = wleft[k] > 0;
        lu = s.v && pex[k].ld && (hits(pex[k], s.rs1, s.u1, zr[k]) || hits(pex[k], s.rs2, s.u2, zr[k]));
        bh = s.v && s.br && (hits(pex[k], s.rs1, s.u1, zr[k]) || hits(pex[k], s.rs2, s.u2, zr[k])
             || (pmem[k].ld && (hits(pmem[k], s.rs1, s.u1, zr[k]) || hits(pmem[k], s.rs2, s.u2, zr[k]))));
        hz = !wt && (lu || bh);
        x.sf  = wt || hz;
        x.bx  = hz;
        x.sb  = wt;
        x.fl  = !wt && !hz && s.v && s.br && s.tk;
        x.fa  = fwd(k, pex[k].rs1, pex[k].u1);
        x.fb  = fwd(k, pex[k].rs2, pex[k].u2);
        x.cnt = cnt[k];
        if (s.clr) cnt[k] = 0;
        else if (x.sf && cnt[k] < cmax[k]) cnt[k] = cnt[k] + 1;
        if (wt) begin
            wleft[k] = wleft[k] - 1;
        end else begin
            pwb[k]  = pmem[k];
            pmem[k] = pex[k];
            pex[k]  = (x.bx || x.fl || !s.v) ? nop() : s;
            if (pmem[k].v && pmem[k].ld && lat[k] > 1) wleft[k] = lat[k] - 1;
        end
    endtask

    task automatic issue(input instr_t s, input bit rst_n, output bit stalled);
        exp_t ea, eb;
        reset         = rst_n;
        dec_valid     = s.v;
        dec_rs1       = 4'(s.rs1);
        dec_rs2       = 4'(s.rs2);
        dec_use_rs1   = s.u1;
        dec_use_rs2   = s.u2;
        dec_rd        = 4'(s.rd);
        dec_wre       = s.we;
        dec_is_load   = s.ld;
        dec_is_branch = s.br;
        branch_taken  = s.tk;
        cnt_clear     = s.clr;
        step(0, s, rst_n, ea);
        step(1, s, rst_n, eb);
        qa.push_back(ea);
        qb.push_back(eb);
        stalled = ea.sf;
        @(posedge clk);
        #1;
    endtask

    // Holds the instruction in decode while the latency-1 controller stalls the front end.
    task automatic send(input instr_t s);
        bit st;
        int n = 0;
        do begin
            issue(s, 1'b1, st);
            n++;
        end while (st && n < 8);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(nop());
    endtask

    task automatic in_reset(input int n);
        bit st;
        for (int i = 0; i < n; i++) issue(nop(), 1'b0, st);
    endtask

    function automatic int rreg();
        if ($urandom_range(0, 7) == 0) return int'($urandom_range(0, 15));
        return int'($urandom_range(0, 3));
    endfunction

    function automatic instr_t rnd();
        instr_t s = '{default: 0};
        int ty = int'($urandom_range(0, 9));
        s.v   = ($urandom_range(0, 7) != 0);
        s.rs1 = rreg(); s.rs2 = rreg(); s.rd = rreg();
        s.u1  = ($urandom_range(0, 3) != 0);
        s.u2  = 1'($urandom_range(0, 1));
        if (ty < 3) begin
            s.ld = 1; s.we = 1; s.u2 = 0;
        end else if (ty < 5) begin
            s.br = 1; s.tk = 1'($urandom_range(0, 1)); s.u1 = 1; s.u2 = 1;
        end else begin
            s.we = ($urandom_range(0, 5) != 0);
        end
        s.clr = ($urandom_range(0, 31) == 0);
        return s;
    endfunction

    task automatic cmp(input string nm, input exp_t w, input logic sf, input logic bx,
                       input logic sb, input logic fl, input logic [1:0] fa, input logic [1:0] fb,
                       input logic [15:0] c);
        n_checks++;
        if (sf !== w.sf || bx !== w.bx || sb !== w.sb || fl !== w.fl
            || fa !== 2'(w.fa) || fb !== 2'(w.fb) || c !== 16'(w.cnt)) begin
            n_fail++;
            $display("FAIL %s t=%0t got sf=%b bx=%b sb=%b fl=%b fa=%0d fb=%0d cnt=%0d required sf=%b bx=%b sb=%b fl=%b fa=%0d fb=%0d cnt=%0d",
                     nm, $time, sf, bx, sb, fl, fa, fb, c, w.sf, w.bx, w.sb, w.fl, w.fa, w.fb, w.cnt);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (qa.size() > 0) begin
            e = qa.pop_front();
            cmp("dut_a", e, sf_a, bx_a, sb_a, fl_a, fa_a, fb_a, cnt_a);
        end
        if (qb.size() > 0) begin
            e = qb.pop_front();
            cmp("dut_b", e, sf_b, bx_b, sb_b, fl_b, fa_b, fb_b, {12'd0, cnt_b});
        end
    end

    initial begin
        bit st;
        @(posedge clk);
        #1;
        in_reset(2);

        send(lw(3, 1));                 // load-use: one stall, then WB forward
        send(alu(5, 3, 1));
        idle(3);

        send(alu(2, 1, 1));             // back-to-back ALU: MEM forward
        send(alu(4, 2, 2));
        idle(3);
        send(alu(2, 1, 1));             // one independent between: WB forward
        send(alu(7, 6, 6));
        send(alu(4, 2, 2));
        idle(3);

        send(beq(1, 6, 1'b1));          // independent taken branch
        idle(2);
        send(alu(2, 1, 1));             // dependent taken branch: stall then flush
        send(beq(2, 1, 1'b1));
        idle(3);
        send(lw(6, 1));                 // load then branch on it
        send(beq(6, 1, 1'b1));
        idle(3);

        send(lw(3, 1));                 // RAM wait on the latency-3 instance
        send(alu(8, 9, 10));
        send(alu(11, 8, 12));
        send(alu(13, 11, 8));
        idle(5);

        send(lw(5, 1));                 // reset lands in the middle of the wait
        send(nop());
        issue(nop(), 1'b0, st);
        send(alu(1, 2, 3));
        idle(3);

        send(alu(0, 1, 2));             // r0 writes and reads
        send(alu(4, 0, 0));
        send(lw(0, 1));
        send(alu(5, 0, 0));
        idle(4);

        for (int i = 0; i < 12; i++) begin
            send(lw(1, 2));
            send(alu(2, 1, 1));
        end
        n_checks++;
        if (cnt_b !== 4'hF) begin
            n_fail++;
            $display("FAIL cnt_saturate got %0d required 15", cnt_b);
        end
        begin
            instr_t c = nop();
            c.clr = 1;
            send(c);
        end
        n_checks++;
        if (cnt_a !== 16'd0 || cnt_b !== 4'd0) begin
            n_fail++;
            $display("FAIL cnt_clear got a=%0d b=%0d required 0", cnt_a, cnt_b);
        end
        idle(3);

        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 49) == 0) in_reset(int'($urandom_range(1, 2)));
            else send(rnd());
        end
        idle(3);

        @(posedge clk);
        #1;
        n_checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got %0d/%0d pending required 0", qa.size(), qb.size());
        end
        done = 1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        if (!done) begin
            n_fail++;
            $display("FAIL watchdog got timeout required completion");
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $finish;
        end
    end

endmodule
